// File: rtl/peripheral_tl_pkg.sv
// Shared TL-UL definitions for the peripheral RAM responder.
// Holds the A/D channel opcode encodings, the responder state type and a
// helper that derives the byte-lane mask a full-width Put must carry.
package peripheral_tl_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  // D-channel opcodes
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StResp
  } tl_state_e;

  // Lanes covered by a naturally aligned transfer of 2**size bytes.
  function automatic logic [3:0] full_mask(logic [1:0] size, logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      2'd0:    mask = 4'b0001 << addr_lo;
      2'd1:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/peripheral_ram_tl_responder.sv
// TL-UL responder in front of a byte-write RAM with 1-cycle read latency.
// Accepts Get / PutFullData / PutPartialData, one transaction outstanding.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a_*                   TL-UL A channel (request) from the crossbar
//   d_*                   TL-UL D channel (response), held until d_ready
//   ram_we/din            byte write enables and write data (write at accept edge)
//   ram_waddr/raddr       word address, taken straight from a_address
//   ram_dout              RAM read data, valid the cycle after raddr is sampled
module peripheral_ram_tl_responder
  import peripheral_tl_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned DW     = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SRC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // A channel
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [1:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_mask,
  input  logic [DW-1:0]     a_data,
  // D channel
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic [DW-1:0]     d_data,
  output logic              d_error,
  // RAM port
  output logic [3:0]        ram_we,
  output logic [DW-1:0]     ram_din,
  output logic [AW-1:0]     ram_waddr,
  output logic [AW-1:0]     ram_raddr,
  input  logic [DW-1:0]     ram_dout
);

  tl_state_e        state_q, state_d;
  logic [2:0]       d_opcode_q, d_opcode_d;
  logic [1:0]       d_size_q, d_size_d;
  logic [SRC_W-1:0] d_source_q, d_source_d;
  logic [DW-1:0]    d_data_q, d_data_d;
  logic             d_error_q, d_error_d;

  logic accept, is_put, is_get, err;
  logic err_op, err_range, err_size, err_align, err_mask;

  assign a_ready = (state_q == StIdle);
  assign accept  = a_valid & a_ready;

  assign is_put = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
  assign is_get = (a_opcode == GET);

  assign err_op    = !(is_put || is_get);
  assign err_range = |a_address[ADDR_W-1:AW+2];
  assign err_size  = (a_size == 2'd3);
  assign err_align = ((a_size == 2'd1) && a_address[0]) ||
                     ((a_size == 2'd2) && (a_address[1:0] != 2'b00));
  assign err_mask  = (a_opcode == PUT_FULL) && (a_mask != full_mask(a_size, a_address[1:0]));
  assign err       = err_op | err_range | err_size | err_align | err_mask;

  // The RAM addresses follow the request combinationally so the write and the
  // read launch on the accept edge itself.
  assign ram_waddr = a_address[AW+1:2];
  assign ram_raddr = a_address[AW+1:2];
  assign ram_din   = a_data;
  assign ram_we    = (accept && is_put && !err) ? a_mask : 4'b0000;

  always_comb begin
    state_d    = state_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          d_size_d   = a_size;
          d_source_d = a_source;
          d_error_d  = err;
          d_data_d   = '0;
          d_opcode_d = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
          // Rejected Gets skip the RAM read and answer immediately with zero data.
          state_d    = (is_get && !err) ? StRdWait : StResp;
        end
      end
      StRdWait: begin
        d_data_d = ram_dout;
        state_d  = StResp;
      end
      StResp: begin
        if (d_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
      d_error_q  <= d_error_d;
    end
  end

  assign d_valid  = (state_q == StResp);
  assign d_opcode = d_opcode_q;
  assign d_size   = d_size_q;
  assign d_source = d_source_q;
  assign d_data   = d_data_q;
  assign d_error  = d_error_q;

endmodule

// File: tb/tb_peripheral_ram_tl_responder.sv
// Self-checking bench for peripheral_ram_tl_responder: a behavioural RAM sits
// beside the responder, requests push their expected response to a queue and
// a negedge monitor pops and compares each D-channel response.
module tb_peripheral_ram_tl_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [3:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;
  logic [3:0]  ram_we;
  logic [31:0] ram_din, ram_dout;
  logic [AW-1:0] ram_waddr, ram_raddr;

  peripheral_ram_tl_responder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_data    (d_data),
    .d_error   (d_error),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural byte-write RAM, read-first, 1-cycle read latency.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    ram_dout <= mem[ram_raddr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [3:0]  src;
    logic [31:0] data;
    logic        err;
    logic [31:0] acc;
    logic [31:0] lat;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] ref_mem [DEPTH];

  // Response monitor
  exp_t        mon_e;
  logic        mon_busy = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_src;
  logic [2:0]  held_op;
  logic        held_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
    end else begin
      if (!(a_valid && a_ready)) check_eq("ram_we_idle", {28'b0, ram_we}, 32'd0);
      if (d_valid) begin
        if (!mon_busy) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_resp", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q[0];
            check_eq("latency", cyc - mon_e.acc, mon_e.lat);
            check_eq("d_opcode", {29'b0, d_opcode}, (mon_e.op == 3'd4) ? 32'd1 : 32'd0);
            check_eq("d_size", {30'b0, d_size}, {30'b0, mon_e.sz});
            check_eq("d_source", {28'b0, d_source}, {28'b0, mon_e.src});
            check_eq("d_error", {31'b0, d_error}, {31'b0, mon_e.err});
            if (mon_e.op == 3'd4) check_eq("d_data", d_data, mon_e.data);
          end
        end else begin
          check_eq("hold_data", d_data, held_data);
          check_eq("hold_source", {28'b0, d_source}, {28'b0, held_src});
          check_eq("hold_opcode", {29'b0, d_opcode}, {29'b0, held_op});
          check_eq("hold_error", {31'b0, d_error}, {31'b0, held_err});
        end
        held_data = d_data;
        held_src  = d_source;
        held_op   = d_opcode;
        held_err  = d_error;
        mon_busy  = 1'b1;
        if (d_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          mon_busy = 1'b0;
        end
      end else begin
        mon_busy = 1'b0;
      end
    end
  end

  // Issues one request; entered and left just after a rising edge.
  task automatic tl_req(input logic [2:0] op, input logic [1:0] sz, input logic [3:0] src,
                        input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic exp_err,
                        input logic [31:0] exp_data);
    exp_t e;
    logic done;
    logic is_put;
    logic [3:0] exp_we;
    is_put = (op == 3'd0) || (op == 3'd1);
    exp_we = (is_put && !exp_err) ? mask : 4'b0000;
    done = 1'b0;
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = data;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (a_ready) begin
        check_eq("ram_addr", {24'b0, ram_raddr}, {24'b0, addr[AW+1:2]});
        check_eq("ram_we", {28'b0, ram_we}, {28'b0, exp_we});
        if (exp_we != 4'b0000) check_eq("ram_din", ram_din, data);
        e.op = op; e.sz = sz; e.src = src; e.data = exp_data; e.err = exp_err;
        e.acc = cyc;
        e.lat = (op == 3'd4 && !exp_err) ? 32'd2 : 32'd1;
        exp_q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    if (exp_we != 4'b0000) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) ref_mem[addr[AW+1:2]][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (exp_q.size() != 0 || d_valid); i++) @(negedge clk);
    check_eq("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] addr, data;
    logic [3:0]  mask;
    logic [2:0]  idx;

    rst_n = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    a_opcode = '0; a_size = '0; a_source = '0; a_address = '0; a_mask = '0; a_data = '0;
    @(negedge clk);
    check_eq("rst_d_valid", {31'b0, d_valid}, 32'd0);
    check_eq("rst_d_opcode", {29'b0, d_opcode}, 32'd0);
    check_eq("rst_d_size", {30'b0, d_size}, 32'd0);
    check_eq("rst_d_source", {28'b0, d_source}, 32'd0);
    check_eq("rst_d_data", d_data, 32'd0);
    check_eq("rst_d_error", {31'b0, d_error}, 32'd0);
    check_eq("rst_a_ready", {31'b0, a_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write, read back, partial write, read back
    tl_req(3'd0, 2'd2, 4'h1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    tl_req(3'd4, 2'd2, 4'h2, 32'h10, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF);
    tl_req(3'd1, 2'd2, 4'h3, 32'h10, 4'h2, 32'h0000AA00, 1'b0, 32'h0);
    tl_req(3'd4, 2'd2, 4'h4, 32'h10, 4'hF, 32'h0,        1'b0, 32'hDEADAAEF);

    // Rejected requests
    tl_req(3'd4, 2'd2, 4'h6, 32'h400, 4'hF, 32'h0,        1'b1, 32'h0);
    tl_req(3'd2, 2'd2, 4'h7, 32'h14,  4'hF, 32'h11111111, 1'b1, 32'h0);
    tl_req(3'd0, 2'd2, 4'h8, 32'h3,   4'hF, 32'h22222222, 1'b1, 32'h0);
    tl_req(3'd0, 2'd3, 4'h9, 32'h18,  4'hF, 32'h33333333, 1'b1, 32'h0);
    tl_req(3'd0, 2'd1, 4'hA, 32'h23,  4'hC, 32'h44444444, 1'b1, 32'h0);
    tl_req(3'd0, 2'd0, 4'hB, 32'h21,  4'h1, 32'h55555555, 1'b1, 32'h0);
    // Legal sub-word full writes
    tl_req(3'd0, 2'd0, 4'hC, 32'h21,  4'h2, 32'h0000AB00, 1'b0, 32'h0);
    tl_req(3'd0, 2'd1, 4'hD, 32'h22,  4'hC, 32'hCDEF0000, 1'b0, 32'h0);
    tl_req(3'd4, 2'd0, 4'hE, 32'h21,  4'h2, 32'h0,        1'b0, ref_mem[8]);
    // Rejected ones must not have touched the words they pointed at
    tl_req(3'd4, 2'd2, 4'h1, 32'h10,  4'hF, 32'h0,        1'b0, 32'hDEADAAEF);
    drain();

    // Backpressure on a read response
    d_ready = 1'b0;
    tl_req(3'd4, 2'd2, 4'h7, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADAAEF);
    for (int i = 0; i < 10 && !d_valid; i++) @(negedge clk);
    check_eq("stall_valid_seen", {31'b0, d_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_a_ready", {31'b0, a_ready}, 32'd0);
      check_eq("stall_d_valid", {31'b0, d_valid}, 32'd1);
    end
    @(posedge clk); #1 d_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("stall_done", {31'b0, d_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset while a read is in flight
    tl_req(3'd0, 2'd2, 4'h2, 32'h40, 4'hF, 32'h12345678, 1'b0, 32'h0);
    tl_req(3'd4, 2'd2, 4'h5, 32'h40, 4'hF, 32'h0, 1'b0, 32'h12345678);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("rst_mid_d_valid", {31'b0, d_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_d_valid", {31'b0, d_valid}, 32'd0);
      check_eq("post_rst_a_ready", {31'b0, a_ready}, 32'd1);
    end
    @(posedge clk); #1;
    tl_req(3'd4, 2'd2, 4'h5, 32'h40, 4'hF, 32'h0, 1'b0, 32'h12345678);

    // Random word traffic over a small window
    for (int i = 0; i < 8; i++) begin
      tl_req(3'd0, 2'd2, 4'h3, 32'h100 + 4 * i, 4'hF, $urandom, 1'b0, 32'h0);
    end
    for (int i = 0; i < 24; i++) begin
      idx  = 3'($urandom_range(0, 7));
      addr = 32'h100 + 4 * idx;
      if ($urandom_range(0, 1) == 0) begin
        tl_req(3'd4, 2'd2, 4'($urandom), addr, 4'hF, 32'h0, 1'b0, ref_mem[addr[AW+1:2]]);
      end else begin
        mask = 4'($urandom);
        data = $urandom;
        tl_req(3'd1, 2'd2, 4'($urandom), addr, mask, data, 1'b0, 32'h0);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/peripheral_ram_tl_responder.md
Name: peripheral_ram_tl_responder

Overview:
- TileLink-UL (TL-UL) responder that accepts Get/PutFullData/PutPartialData requests and converts them into RAM port controls.
- Drives the team's generic byte-write RAM (peripheral_ram_generic_tl): byte enables, write data, write/read word addresses, 1-cycle registered read data.
- Sits between the TL-UL crossbar and the RAM inside the peripheral_ram_tl wrapper.
- One outstanding transaction; full backpressure on the D channel.

Parameters:
- DEPTH, 256, RAM depth in 32-bit words.
- AW, $clog2(DEPTH), RAM word-address width.
- DW, 32, data width (fixed 32; 4 byte lanes).
- ADDR_W, 32, TL address width.
- SRC_W, 4, TL source-ID width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_valid  in  1  A-channel request valid.
- a_ready  out  1  A-channel ready.
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
- a_size  in  2  log2 of transfer bytes.
- a_source  in  SRC_W  requester ID.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte-lane mask.
- a_data  in  DW  write data.
- d_valid  out  1  D-channel response valid.
- d_ready  in  1  D-channel ready.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_size  out  2  echoed a_size.
- d_source  out  SRC_W  echoed a_source.
- d_data  out  DW  read data, registered.
- d_error  out  1  request was rejected.
- ram_we  out  4  RAM byte write enables.
- ram_din  out  DW  RAM write data (= a_data).
- ram_waddr  out  AW  RAM write word address.
- ram_raddr  out  AW  RAM read word address.
- ram_dout  in  DW  RAM read data; valid one cycle after ram_raddr is sampled.

Behaviour:
- States: IDLE, RDWAIT, RESP. Reset state is IDLE.
- Reset values: d_valid=0, d_opcode=0, d_size=0, d_source=0, d_data=0, d_error=0.
- a_ready=1 only in IDLE; accept = a_valid & a_ready.
- ram_waddr = ram_raddr = a_address[AW+1:2] at all times; both are combinational.
- err is set at accept if any of the following hold:
  - opcode is not in {0,1,4};
  - a_address[ADDR_W-1:AW+2] != 0;
  - a_size > 2;
  - a_address misaligned for a_size (size 1 with addr[0]=1, or size 2 with addr[1:0]!=0);
  - PutFullData with a_mask != size-derived full mask.
- ram_we = a_mask when accept & Put & !err; otherwise 4'b0000. The write commits at the accept edge.
- Put accepted, IDLE -> RESP:
  - d_opcode=AccessAck; size and source latched; d_error=err.
  - d_valid=1 on the cycle after accept.
- Get accepted, no error, IDLE -> RDWAIT.
  - RDWAIT -> RESP unconditionally; at that edge d_data <= ram_dout and d_opcode=AccessAckData.
  - d_valid=1 two cycles after accept.
- Get accepted with error, IDLE -> RESP directly: d_opcode=AccessAckData, d_data=0, d_error=1.
- In RESP, all d_* outputs are held stable until d_ready=1. On d_valid & d_ready: RESP -> IDLE, d_valid=0.
- Throughput: one Put per 2 cycles; one Get per 3 cycles (with d_ready held high).
- Read-after-write to the same word returns the new data, because the write commits before the following Get is accepted.
- rst_n asserted mid-transaction (any state):
  - immediate return to IDLE with d_valid=0 and ram_we=0;
  - the pending response is dropped;
  - RAM contents are not cleared.
- a_valid while not in IDLE is ignored (a_ready=0); the requester must hold its request.

Decomposition:
- Package peripheral_tl_pkg holds:
  - TL opcode localparams (PUT_FULL=3'd0, PUT_PARTIAL=3'd1, GET=3'd4, ACCESS_ACK=3'd0, ACCESS_ACK_DATA=3'd1);
  - state enum typedef (IDLE, RDWAIT, RESP).
- No sub-module inside this block. The RAM is instantiated beside it in the peripheral_ram_tl wrapper.

Test Plan:
- PutFullData addr 0x10, data 0xDEADBEEF, mask 0xF; then Get addr 0x10 -> AccessAck with d_error=0; then AccessAckData with d_data=0xDEADBEEF, d_valid exactly 2 cycles after the Get accept.
- PutPartialData addr 0x10, mask 0x2, data 0x0000AA00 over 0xDEADBEEF -> Get returns 0xDEADAAEF.
- Get addr 0x400 with DEPTH=256 (out of range) -> AccessAckData with d_error=1, d_data=0; ram_we stays 0 throughout.
- Opcode 3'd2 -> AccessAck with d_error=1, no RAM write. Then PutFullData size=2 at addr 0x3 -> d_error=1.
- d_ready held 0 for 5 cycles during a read response -> d_valid, d_data and d_source stay stable; a_ready=0 throughout; completes on the first d_ready=1 cycle.
- rst_n pulsed low in RDWAIT with source 0x5 -> d_valid=0 and a_ready=1 after release, no stale response; a following Get of the same word returns the previously written data.
